instr_mem_multiport: RTL and testbench
======================================

// Module: instr_mem_multiport
// PURPOSE
// Parametrised, NUM_PORTS-read / 1-write instruction store for the matrix-multiply core array.
// A streaming loader fills it from address 0 with a valid/ready handshake; each core then fetches through its own read port.
// Adds a load FSM, explicit load completion, read-valid flags, overflow detection,
// and FILL_WORD substitution for addresses beyond the loaded program.
// PARAMETERS
// DATA_W     8      instruction word width
// ADDR_W     8      address width; DEPTH = 2**ADDR_W words
// NUM_PORTS  4      number of independent read ports (one per core)
// FILL_WORD  8'd38  word returned for addresses >= load_count (END opcode halts the core)
// PORTS
// clock       in   1                   single clock; all logic on posedge
// reset       in   1                   synchronous, active-high
// load_start  in   1                   pulse: begin (re)load at address 0
// load_valid  in   1                   loader word present
// load_data   in   DATA_W              loader word
// load_last   in   1                   qualifies final word of program
// load_ready  out  1                   store accepts a word this cycle
// load_done   out  1                   program loaded, reads enabled
// load_ovf    out  1                   sticky: program hit DEPTH without load_last
// load_count  out  ADDR_W+1            number of words in current program
// rd_en       in   NUM_PORTS           per-port fetch request
// rd_addr     in   NUM_PORTS*ADDR_W    port i at [i*ADDR_W +: ADDR_W]
// rd_data     out  NUM_PORTS*DATA_W    port i at [i*DATA_W +: DATA_W]
// rd_valid    out  NUM_PORTS           port i rd_data valid this cycle
// BEHAVIOUR
// - Reset: state IDLE, write ptr=0, load_count=0, load_ready=0, load_done=0, load_ovf=0, rd_valid=0, rd_data=0. RAM contents not cleared.
// - FSM: IDLE -> LOAD on load_start; LOAD -> RUN on accepted beat with load_last or beat at ptr=DEPTH-1;
//   RUN -> LOAD on load_start. No other transitions; reset from any state -> IDLE.
// - Entering LOAD (from any state, incl. load_start during LOAD): ptr=0, load_count=0, load_done=0, load_ovf=0.
// - load_ready=1 only in LOAD; also 0 in the cycle load_start is sampled.
//   Beat accepted when load_valid & load_ready: mem[ptr]<=load_data, ptr++, load_count++.
// - Beat at ptr=DEPTH-1 without load_last: word written, load_count=DEPTH, load_ovf<=1, go RUN.
//   With load_last: same but load_ovf stays 0.
// - load_done=1 exactly while in RUN (registered; asserts the cycle after the final beat).
// - Reads, latency 1: in RUN, rd_en[i] at edge N -> at N+1 rd_valid[i]=1 and rd_data[i] set as follows:
//   rd_data[i]=mem[rd_addr[i]] if rd_addr[i] < load_count, else FILL_WORD.
// - rd_en[i]=0, or state != RUN: rd_valid[i]<=0, rd_data[i] holds its previous value.
// - Ports are fully independent; any number may read the same address in the same cycle.
// - Load and read never overlap (reads gated by state), so there is no read-during-write hazard.
// - Reset mid-load: load abandoned, load_count=0; no reads until a new load completes.
// TESTING
// 1 reset, then rd_en=4'hF in IDLE -> rd_valid=0, rd_data=0; load_ready=0.
// 2 load_start, stream 5 words 9,11,12,13,38 (last on 38) -> load_count=5; load_done=1 next cycle; load_ovf=0.
// 3 RUN, ports 0-3 read addr 0,2,4,4 same cycle -> next cycle rd_data=9,12,38,38, rd_valid=4'hF.
// 4 read addr 7 after test 2 -> rd_data=FILL_WORD (38), rd_valid=1.
// 5 stream 256 words with no load_last -> load_ovf=1, load_count=256, RUN; mem[255] readable.
// 6 reset after 3 of 5 load beats -> IDLE, load_count=0; reads give rd_valid=0.
// 7 load_start in RUN mid-read -> load_done=0 next cycle; rd_valid drops; reload of 2 words -> load_count=2.

Source files
------------

// File: rtl/instr_mem_multiport.sv
// Multi-port instruction store: one streaming loader writes from address 0, and each core reads through its own port.
// A read at or beyond load_count returns FILL_WORD, so a core that runs past its program fetches END and halts.

module instr_mem_rd_lane #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter logic [DATA_W-1:0] FILL_WORD = 8'd38
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W:0]   count,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] data,
  output logic              valid
);
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (en) begin
      valid <= 1'b1;
      data  <= ({1'b0, addr} < count) ? word : FILL_WORD;
    end else begin
      valid <= 1'b0;
    end
  end
endmodule

module instr_mem_multiport #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int NUM_PORTS = 4,
  parameter logic [DATA_W-1:0] FILL_WORD = 8'd38
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        load_start,
  input  logic                        load_valid,
  input  logic [DATA_W-1:0]           load_data,
  input  logic                        load_last,
  output logic                        load_ready,
  output logic                        load_done,
  output logic                        load_ovf,
  output logic [ADDR_W:0]             load_count,
  input  logic [NUM_PORTS-1:0]        rd_en,
  input  logic [NUM_PORTS*ADDR_W-1:0] rd_addr,
  output logic [NUM_PORTS*DATA_W-1:0] rd_data,
  output logic [NUM_PORTS-1:0]        rd_valid
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept;
  logic              ptr_end;

  assign load_ready = (state == LOAD) && !load_start;
  assign accept     = load_valid && load_ready;
  assign ptr_end    = &ptr;
  assign load_done  = (state == RUN);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // load_start re-enters LOAD from every state, including mid-load
  always_comb begin
    state_nxt = state;
    if (load_start)
      state_nxt = LOAD;
    else if (accept && (load_last || ptr_end))
      state_nxt = RUN;
  end

  always_ff @(posedge clock) begin
    if (reset || load_start) begin
      ptr        <= '0;
      load_count <= '0;
      load_ovf   <= 1'b0;
    end else if (accept) begin
      ptr        <= ptr + 1'b1;
      load_count <= load_count + 1'b1;
      if (ptr_end && !load_last) load_ovf <= 1'b1;
    end
  end

  // RAM contents survive reset; load_count alone defines what is valid
  always_ff @(posedge clock) begin
    if (accept) mem[ptr] <= load_data;
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    instr_mem_rd_lane #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FILL_WORD(FILL_WORD)
    ) u_lane (
      .clock(clock),
      .reset(reset),
      .en   (rd_en[i] && (state == RUN)),
      .addr (rd_addr[i*ADDR_W +: ADDR_W]),
      .count(load_count),
      .word (mem[rd_addr[i*ADDR_W +: ADDR_W]]),
      .data (rd_data[i*DATA_W +: DATA_W]),
      .valid(rd_valid[i])
    );
  end
endmodule

// File: tb/tb_instr_mem_multiport.sv
// Directed-plus-random bench for instr_mem_multiport against a queue-based program model.
module tb_instr_mem_multiport;
  localparam int NP = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam logic [DW-1:0] FILL = 8'd38;

  logic              clock = 1'b0;
  logic              reset, load_start, load_valid, load_last;
  logic [DW-1:0]     load_data;
  logic              load_ready, load_done, load_ovf;
  logic [AW:0]       load_count;
  logic [NP-1:0]     rd_en;
  logic [NP*AW-1:0]  rd_addr;
  logic [NP*DW-1:0]  rd_data;
  logic [NP-1:0]     rd_valid;

  instr_mem_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_PORTS(NP), .FILL_WORD(FILL)) dut (
    .clock(clock), .reset(reset),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .load_done(load_done), .load_ovf(load_ovf), .load_count(load_count),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int errs = 0;
  logic [DW-1:0] prog[$];
  logic [DW-1:0] last_d [NP];
  bit model_run = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_word(input logic [AW-1:0] a);
    return (int'(a) < prog.size()) ? prog[a] : FILL;
  endfunction

  // Issue load_start, stream prog with random bubbles, then check completion.
  task automatic load_prog(input bit use_last, input bit exp_ovf, input string tag);
    load_start = 1'b1;
    #1 chk({tag, "_ready_at_start"}, load_ready, 0);
    tick();
    load_start = 1'b0;
    model_run = 0;
    #1;
    chk({tag, "_ready"}, load_ready, 1);
    chk({tag, "_done_clr"}, load_done, 0);
    chk({tag, "_cnt_clr"}, load_count, 0);
    for (int i = 0; i < prog.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        load_valid = 1'b0;
        tick();
      end
      load_valid = 1'b1;
      load_data  = prog[i];
      load_last  = use_last && (i == prog.size() - 1);
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    model_run  = 1;
    chk({tag, "_done"}, load_done, 1);
    chk({tag, "_count"}, load_count, prog.size());
    chk({tag, "_ovf"}, load_ovf, exp_ovf);
    chk({tag, "_ready_run"}, load_ready, 0);
  endtask

  task automatic do_read(input logic [NP-1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [AW-1:0] a3, input string tag);
    logic [AW-1:0] addrs [NP];
    addrs[0] = a0; addrs[1] = a1; addrs[2] = a2; addrs[3] = a3;
    rd_en = en;
    for (int i = 0; i < NP; i++) rd_addr[i*AW +: AW] = addrs[i];
    tick();
    rd_en = '0;
    for (int i = 0; i < NP; i++) begin
      if (model_run && en[i]) last_d[i] = ref_word(addrs[i]);
      chk($sformatf("%s_v%0d", tag, i), rd_valid[i], model_run && en[i]);
      chk($sformatf("%s_d%0d", tag, i), rd_data[i*DW +: DW], last_d[i]);
    end
  endtask

  initial begin
    reset = 1'b1; load_start = 0; load_valid = 0; load_last = 0; load_data = '0;
    rd_en = '0; rd_addr = '0;
    for (int i = 0; i < NP; i++) last_d[i] = '0;
    tick(); tick();
    reset = 1'b0;

    // 1: idle after reset
    chk("rst_ready", load_ready, 0);
    chk("rst_done", load_done, 0);
    chk("rst_ovf", load_ovf, 0);
    chk("rst_count", load_count, 0);
    do_read(4'hF, 0, 1, 2, 3, "idle_rd");

    // 2-4: short program, parallel reads, past-end fill
    prog = '{8'd9, 8'd11, 8'd12, 8'd13, 8'd38};
    load_prog(1, 0, "ld5");
    do_read(4'hF, 0, 2, 4, 4, "rd_0244");
    do_read(4'h1, 7, 0, 0, 0, "rd_fill");
    do_read(4'hA, 5, 1, 255, 3, "rd_mask");

    // random program with random multi-port reads (often colliding)
    prog.delete();
    for (int i = 0, n = $urandom_range(10, 60); i < n; i++) prog.push_back(DW'($urandom));
    load_prog(1, 0, "ldr");
    for (int k = 0; k < 20; k++) begin
      logic [AW-1:0] base;
      base = AW'($urandom_range(0, 70));
      do_read(NP'($urandom),
              ($urandom_range(0, 1) != 0) ? base : AW'($urandom_range(0, 70)),
              base, AW'($urandom), ($urandom_range(0, 1) != 0) ? base : AW'($urandom_range(0, 70)),
              "rd_rand");
    end

    // 5: full-depth program without load_last
    prog.delete();
    for (int i = 0; i < 2 ** AW; i++) prog.push_back(DW'($urandom));
    load_prog(0, 1, "ld256");
    do_read(4'hF, 255, 0, 128, 255, "rd_full");

    // full-depth with load_last on the final word: no overflow
    prog.delete();
    for (int i = 0; i < 2 ** AW; i++) prog.push_back(DW'($urandom));
    load_prog(1, 0, "ld256l");
    do_read(4'h9, 255, 0, 0, 254, "rd_full_l");

    // 6: reset after 3 of 5 beats
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    model_run = 0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = DW'(i + 1); tick();
    end
    load_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NP; i++) last_d[i] = '0;
    chk("midrst_count", load_count, 0);
    chk("midrst_done", load_done, 0);
    chk("midrst_ready", load_ready, 0);
    do_read(4'hF, 0, 1, 2, 3, "midrst_rd");

    // 7: reload from RUN while reading
    prog = '{8'd1, 8'd2, 8'd3};
    load_prog(1, 0, "ld3");
    rd_en = 4'hF;
    for (int i = 0; i < NP; i++) rd_addr[i*AW +: AW] = AW'(i);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    model_run = 0;
    chk("rl_done", load_done, 0);
    chk("rl_valid_last", rd_valid, 4'hF);
    chk("rl_data_last", rd_data, {FILL, 8'd3, 8'd2, 8'd1});
    tick();
    chk("rl_valid_drop", rd_valid, 0);
    chk("rl_data_hold", rd_data, {FILL, 8'd3, 8'd2, 8'd1});
    rd_en = '0;
    for (int i = 0; i < NP; i++) last_d[i] = (i < 3) ? DW'(i + 1) : FILL;
    prog = '{8'hA5, 8'h5A};
    load_prog(1, 0, "ld2");
    do_read(4'hF, 0, 1, 2, 3, "rd_ld2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
